// File: rtl/tri_pkg.sv
// Shared triangle/vertex types used by the vertex shader, this serializer and the rasterizer.
package tri_pkg;

   localparam int unsigned COORD_W    = 32;
   localparam int unsigned NUM_COORDS = 4;
   localparam int unsigned NUM_VERTS  = 3;

   typedef logic signed [COORD_W-1:0]          coord_t;
   typedef coord_t [NUM_COORDS-1:0]            vertex_t;
   typedef coord_t [NUM_COORDS-1:0][NUM_VERTS-1:0] tri_t;

endpackage

// File: rtl/tri_fifo.sv
// Register FIFO of whole triangles; a push into a full FIFO is taken only alongside a pop.
module tri_fifo
   import tri_pkg::*;
#(
   parameter int unsigned WIDTH = COORD_W,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic                                             clk_in,
   input  logic                                             rst_in,
   input  logic                                             push,
   input  logic                                             pop,
   input  logic [NUM_COORDS-1:0][NUM_VERTS-1:0][WIDTH-1:0]  data,
   output logic                                             full,
   output logic                                             empty,
   output logic [CNT_W-1:0]                                 count,
   output logic [NUM_COORDS-1:0][NUM_VERTS-1:0][WIDTH-1:0]  head
);

   logic [NUM_COORDS-1:0][NUM_VERTS-1:0][WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_en;
   logic             pop_en;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pop_en  = pop & ~empty;
   assign push_en = push & (~full | pop_en);
   assign head    = mem[rd_ptr];

   // Storage needs no reset: reads are only meaningful while count != 0.
   always_ff @(posedge clk_in) begin
      if (push_en) mem[wr_ptr] <= data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tri_vertex_serializer.sv
// Buffers parallel triangles from the shader and streams them one vertex per beat,
// counting triangles dropped when the buffer is full.
module tri_vertex_serializer
   import tri_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                                             clk_in,
   input  logic                                             rst_in,
   input  logic [NUM_COORDS-1:0][NUM_VERTS-1:0][WIDTH-1:0]  tri_in,
   input  logic                                             valid_in,
   output logic                                             ready_out,
   output logic [NUM_COORDS-1:0][WIDTH-1:0]                 vtx_out,
   output logic [1:0]                                       vtx_idx_out,
   output logic                                             last_out,
   output logic                                             valid_out,
   input  logic                                             ready_in,
   output logic                                             overflow_out,
   output logic [15:0]                                      drop_count_out
);

   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned DROP_W = 16;

   logic [NUM_COORDS-1:0][NUM_VERTS-1:0][WIDTH-1:0] head;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic [1:0]       vcnt;
   logic             beat;
   logic             pop_tri;
   logic             push_ok;
   logic             drop;

   assign beat    = valid_out & ready_in;
   assign pop_tri = beat & (vcnt == 2'd2);
   assign push_ok = valid_in & (~full | pop_tri);
   assign drop    = valid_in & ~push_ok;

   tri_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (push_ok),
      .pop    (pop_tri),
      .data   (tri_in),
      .full   (full),
      .empty  (empty),
      .count  (count),
      .head   (head)
   );

   // Vertex index within the head triangle; wraps after the last vertex.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         vcnt <= 2'd0;
      end else if (beat) begin
         vcnt <= (vcnt == 2'd2) ? 2'd0 : vcnt + 2'd1;
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         overflow_out   <= 1'b0;
         drop_count_out <= '0;
      end else if (drop) begin
         overflow_out <= 1'b1;
         if (drop_count_out != '1) drop_count_out <= drop_count_out + DROP_W'(1);
      end
   end

   assign valid_out   = ~empty;
   assign ready_out   = (count < CNT_W'(DEPTH));
   assign vtx_idx_out = vcnt;
   assign last_out    = (vcnt == 2'd2);

   // Gated by valid so stale storage never shows on the bus after reset.
   always_comb begin
      vtx_out = '0;
      if (valid_out) begin
         for (int unsigned c = 0; c < NUM_COORDS; c++) begin
            case (vcnt)
               2'd0:    vtx_out[c] = head[c][0];
               2'd1:    vtx_out[c] = head[c][1];
               default: vtx_out[c] = head[c][2];
            endcase
         end
      end
   end

endmodule
